// File: rtl/ext_mem_loader.sv
// ext_mem_loader: host byte-stream command engine driving the CPU's
// external IMEM/DMEM ports and run enable.
module ext_mem_loader #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        enable,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WR_COLLECT,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_SEND
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  hcnt_q, hcnt_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [2:0]  wait_q, wait_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic        dmem_q, dmem_d;
    logic        rd_q, rd_d;
    logic [63:0] asm_q, asm_d;
    logic        s_ready_q, s_ready_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q, m_data_d;
    logic [63:0] addr_ext_q, addr_ext_d;
    logic        wen_ext_q, wen_ext_d;
    logic        ren_ext_q, ren_ext_d;
    logic [31:0] wdata_ext_q, wdata_ext_d;
    logic [63:0] addr_ext_2_q, addr_ext_2_d;
    logic        wen_ext_2_q, wen_ext_2_d;
    logic        ren_ext_2_q, ren_ext_2_d;
    logic [63:0] wdata_ext_2_q, wdata_ext_2_d;
    logic        enable_q, enable_d;
    logic        error_q, error_d;

    logic        accept;
    logic [2:0]  last_b;

    assign accept = s_valid && s_ready_q;
    assign last_b = dmem_q ? 3'd7 : 3'd3;

    // Command decode, header/payload collection, access sequencing and readback.
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        bcnt_d        = bcnt_q;
        wait_d        = wait_q;
        count_d       = count_q;
        idx_d         = idx_q;
        dmem_d        = dmem_q;
        rd_d          = rd_q;
        asm_d         = asm_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        addr_ext_d    = addr_ext_q;
        wdata_ext_d   = wdata_ext_q;
        addr_ext_2_d  = addr_ext_2_q;
        wdata_ext_2_d = wdata_ext_2_q;
        wen_ext_d     = 1'b0;
        ren_ext_d     = 1'b0;
        wen_ext_2_d   = 1'b0;
        ren_ext_2_d   = 1'b0;
        enable_d      = enable_q;
        error_d       = error_q;
        s_ready_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hcnt_d = 2'd0;
                    case (s_data)
                        8'h01: begin
                            dmem_d = 1'b0; rd_d = 1'b0;
                            enable_d = 1'b0; state_d = S_HDR;
                        end
                        8'h02: begin
                            dmem_d = 1'b1; rd_d = 1'b0;
                            enable_d = 1'b0; state_d = S_HDR;
                        end
                        8'h03: begin
                            dmem_d = 1'b1; rd_d = 1'b1;
                            enable_d = 1'b0; state_d = S_HDR;
                        end
                        8'h06: begin
                            dmem_d = 1'b0; rd_d = 1'b1;
                            enable_d = 1'b0; state_d = S_HDR;
                        end
                        8'h04:   enable_d = 1'b1;
                        8'h05:   enable_d = 1'b0;
                        default: error_d = 1'b1;
                    endcase
                end
            end
            S_HDR: begin
                if (accept) begin
                    hcnt_d = hcnt_q + 2'd1;
                    unique case (hcnt_q)
                        2'd0: count_d[7:0]  = s_data;
                        2'd1: count_d[15:8] = s_data;
                        2'd2: idx_d[7:0]    = s_data;
                        2'd3: begin
                            idx_d[15:8] = s_data;
                            bcnt_d = 3'd0;
                            asm_d  = 64'd0;
                            if (count_q == 16'd0)
                                state_d = S_IDLE;
                            else if (rd_q)
                                state_d = S_RD_ISSUE;
                            else
                                state_d = S_WR_COLLECT;
                        end
                    endcase
                end
            end
            S_WR_COLLECT: begin
                if (accept) begin
                    asm_d[{bcnt_q, 3'b000} +: 8] = s_data;
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == last_b) begin
                        bcnt_d  = 3'd0;
                        state_d = S_WR_ISSUE;
                    end
                end
            end
            S_WR_ISSUE: begin
                count_d = count_q - 16'd1;
                idx_d   = idx_q + 16'd1;
                asm_d   = 64'd0;
                state_d = (count_q == 16'd1) ? S_IDLE : S_WR_COLLECT;
            end
            S_RD_ISSUE: begin
                wait_d  = 3'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q == 3'(RD_LAT - 1)) begin
                    asm_d     = dmem_q ? rdata_ext_2 : {32'd0, rdata_ext};
                    m_data_d  = asm_d[7:0];
                    m_valid_d = 1'b1;
                    bcnt_d    = 3'd0;
                    state_d   = S_RD_SEND;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_RD_SEND: begin
                if (m_valid_q && m_ready) begin
                    if (bcnt_q == last_b) begin
                        m_valid_d = 1'b0;
                        count_d   = count_q - 16'd1;
                        idx_d     = idx_q + 16'd1;
                        state_d   = (count_q == 16'd1) ? S_IDLE : S_RD_ISSUE;
                    end else begin
                        bcnt_d   = bcnt_q + 3'd1;
                        m_data_d = asm_q[15:8];
                        asm_d    = {8'd0, asm_q[63:8]};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        s_ready_d = (state_d == S_IDLE) || (state_d == S_HDR) ||
                    (state_d == S_WR_COLLECT);

        if (state_d == S_WR_ISSUE) begin
            if (dmem_d) begin
                wen_ext_2_d   = 1'b1;
                addr_ext_2_d  = {45'd0, idx_d, 3'b000};
                wdata_ext_2_d = asm_d;
            end else begin
                wen_ext_d   = 1'b1;
                addr_ext_d  = {46'd0, idx_d, 2'b00};
                wdata_ext_d = asm_d[31:0];
            end
        end

        if (state_d == S_RD_ISSUE) begin
            if (dmem_d) begin
                ren_ext_2_d  = 1'b1;
                addr_ext_2_d = {45'd0, idx_d, 3'b000};
            end else begin
                ren_ext_d  = 1'b1;
                addr_ext_d = {46'd0, idx_d, 2'b00};
            end
        end
    end

    // State and registered outputs; synchronous reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hcnt_q        <= 2'd0;
            bcnt_q        <= 3'd0;
            wait_q        <= 3'd0;
            count_q       <= 16'd0;
            idx_q         <= 16'd0;
            dmem_q        <= 1'b0;
            rd_q          <= 1'b0;
            asm_q         <= 64'd0;
            s_ready_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= 8'd0;
            addr_ext_q    <= 64'd0;
            wen_ext_q     <= 1'b0;
            ren_ext_q     <= 1'b0;
            wdata_ext_q   <= 32'd0;
            addr_ext_2_q  <= 64'd0;
            wen_ext_2_q   <= 1'b0;
            ren_ext_2_q   <= 1'b0;
            wdata_ext_2_q <= 64'd0;
            enable_q      <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            bcnt_q        <= bcnt_d;
            wait_q        <= wait_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            dmem_q        <= dmem_d;
            rd_q          <= rd_d;
            asm_q         <= asm_d;
            s_ready_q     <= s_ready_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            addr_ext_q    <= addr_ext_d;
            wen_ext_q     <= wen_ext_d;
            ren_ext_q     <= ren_ext_d;
            wdata_ext_q   <= wdata_ext_d;
            addr_ext_2_q  <= addr_ext_2_d;
            wen_ext_2_q   <= wen_ext_2_d;
            ren_ext_2_q   <= ren_ext_2_d;
            wdata_ext_2_q <= wdata_ext_2_d;
            enable_q      <= enable_d;
            error_q       <= error_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign addr_ext    = addr_ext_q;
    assign wen_ext     = wen_ext_q;
    assign ren_ext     = ren_ext_q;
    assign wdata_ext   = wdata_ext_q;
    assign addr_ext_2  = addr_ext_2_q;
    assign wen_ext_2   = wen_ext_2_q;
    assign ren_ext_2   = ren_ext_2_q;
    assign wdata_ext_2 = wdata_ext_2_q;
    assign enable      = enable_q;
    assign error       = error_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/ext_mem_loader.md
Name: ext_mem_loader

Overview:
- Host-side initiator for the CPU's external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext and their _2 data-memory counterparts).
- Consumes a byte-stream command protocol (valid/ready) from a host link. Writes words into instruction or data memory, streams memory contents back as bytes, and drives the CPU enable.
- Sits between the host link and the cpu top; the CPU's external memory ports are driven only by this block.

Parameters:
- RD_LAT, 1, cycles from ren_ext/ren_ext_2 asserted to rdata_ext/rdata_ext_2 valid (1..4).

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous active-high reset
- s_data  in  8  host command/payload byte
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts s_data this cycle
- m_data  out  8  readback byte to host
- m_valid  out  1  m_data valid
- m_ready  in  1  host accepts m_data
- addr_ext  out  64  IMEM byte address
- wen_ext  out  1  IMEM write strobe
- ren_ext  out  1  IMEM read strobe
- wdata_ext  out  32  IMEM write word
- rdata_ext  in  32  IMEM read word
- addr_ext_2  out  64  DMEM byte address
- wen_ext_2  out  1  DMEM write strobe
- ren_ext_2  out  1  DMEM read strobe
- wdata_ext_2  out  64  DMEM write word
- rdata_ext_2  in  64  DMEM read word
- enable  out  1  CPU run enable
- busy  out  1  state != IDLE
- error  out  1  sticky unknown-command flag

Behaviour:
- Handshakes:
  - A byte transfers on s_valid&s_ready.
  - m_valid, once high, holds with m_data stable until m_valid&m_ready.
- Reset (sync, rst=1 at posedge):
  - State IDLE.
  - Outputs: s_ready=0, m_valid=0, m_data=0, all strobes 0, all addr/wdata 0, enable=0, busy=0, error=0.
  - Word index, count and assembly registers cleared.
  - Reset mid-transfer aborts immediately. No strobe is asserted in the cycle after reset.
- Commands (first byte in IDLE):
  - 0x01 IMEM write; 0x02 DMEM write; 0x03 DMEM read; 0x04 START (enable<=1); 0x05 STOP (enable<=0); 0x06 IMEM read.
  - Any other value: error<=1 (sticky until rst), byte consumed, stay IDLE.
  - Commands 0x01/0x02/0x03/0x06 clear enable in the cycle after the command byte is accepted.
- Header: commands 0x01/0x02/0x03/0x06 are followed by 4 bytes.
  - Bytes 1-2: count[15:0], little-endian.
  - Bytes 3-4: base word index[15:0], little-endian.
  - If count=0, return to IDLE after the header with no memory access.
- Address mapping:
  - IMEM addr_ext = {46'b0, idx, 2'b00}.
  - DMEM addr_ext_2 = {45'b0, idx, 3'b000}.
  - idx increments by 1 per word, modulo 2^16. Wrap from 0xFFFF to 0x0000 is silent.
  - No memory-size checking.
- States: IDLE, HDR, WR_COLLECT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_SEND.
- s_ready:
  - 1 in IDLE, HDR and WR_COLLECT.
  - 0 in WR_ISSUE, RD_ISSUE, RD_WAIT and RD_SEND.
- Write path:
  - WR_COLLECT assembles 4 (IMEM) or 8 (DMEM) bytes, little-endian: first byte goes to bits [7:0].
  - On the last byte, go to WR_ISSUE. There, for exactly one cycle, wen strobe=1 with the address and wdata registered.
  - Then decrement count and increment idx. If count reaches 0, go to IDLE; else go to WR_COLLECT.
  - Write throughput is one word per (bytes+1) cycles.
- Read path:
  - RD_ISSUE: ren strobe=1 for one cycle with the address.
  - RD_WAIT: wait RD_LAT cycles, then capture rdata into a shift register.
  - RD_SEND: emit 4 or 8 bytes LSB first, advancing on each m_ready handshake.
  - After the last byte is accepted, decrement count and increment idx. Then go to RD_ISSUE, or to IDLE if count is 0.
  - ren and wen are never high in the same cycle. IMEM and DMEM strobes are never high together.
- Simultaneous events:
  - rst has priority over everything.
  - START/STOP take effect the cycle after acceptance.
  - s_valid in a non-ready state is ignored; no byte is lost because the host holds the byte.
- busy=1 in every state except IDLE. enable is unaffected by busy except as described for the commands above.

Test Plan:
- Reset: rst=1 for 2 cycles mid DMEM write -> next cycle all strobes 0, enable=0, busy=0, error=0, s_ready=0. The cycle after, s_ready=1.
- IMEM write: bytes 01 02 00 10 00 | 78 56 34 12 | EF BE AD DE -> two single-cycle wen_ext pulses:
  - addr_ext=0x40, wdata_ext=0x12345678;
  - then addr_ext=0x44, wdata_ext=0xDEADBEEF;
  - busy ends after the second pulse.
- DMEM read with backpressure, RD_LAT=1: rdata_ext_2=0x1122334455667788 at idx 3, cmd 03 01 00 03 00, m_ready toggling 1/0 ->
  - single ren_ext_2 pulse with addr_ext_2=0x18;
  - m_data sequence 88 77 66 55 44 33 22 11, each held while m_ready=0.
- Wrap and zero count:
  - cmd 02 02 00 FF FF with 16 payload bytes -> addr_ext_2=0x7FFF8, then 0x0.
  - cmd 01 00 00 05 00 -> no strobes, back to IDLE.
- Control: 04 -> enable=1 next cycle; 01 header follows -> enable=0; 05 -> enable stays 0.
- Error: byte 0x7E in IDLE -> error=1, no strobes; subsequent valid command still executes; error stays 1 until rst.
